counter8_ctrl: RTL and testbench
================================

COUNTER8_CTRL -- requirements
Module: counter8_ctrl

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- _areset  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a sweep job; sampled only in IDLE.
- abort  in  1  returns the block to IDLE from any state.
- lo_val  in  8  sweep floor.
- hi_val  in  8  sweep ceiling.
- cycles  in  4  number of up/down sweeps.
- dcout  in  8  counter value returned from the driven counter.
- overflow  in  1  counter overflow flag.
- _load  out  1  counter preload strobe, active-low.
- preld_val  out  8  counter preload value.
- _updown  out  1  counter direction: 1 = up, 0 = down.
- _wrapstop  out  1  counter wrap mode; constant 0 (stop and flag).
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job completion.
- err  out  1  sticky error flag; cleared by the next accepted start.

REQ-002 All outputs SHALL be registered.
REQ-003 The driven counter SHALL be taken to sample _load, preld_val and _updown on each clk rising edge, with dcout updated one cycle later.

Function
REQ-004 The FSM SHALL have these states: IDLE, LOAD, UP, DOWN, DONE, ERR.
REQ-005 In IDLE, when start=1, the block SHALL latch lo_val, hi_val and cycles.
- lo_val>=hi_val or cycles==0: go to ERR.
- Otherwise: go to LOAD.
REQ-006 LOAD SHALL last exactly one cycle with _load=0 and preld_val=lo latched, then go to UP; _load SHALL be 1 in every other state.
REQ-007 UP SHALL drive _updown=1.
- When dcout==hi-1: go to DOWN, so that the counter peaks at exactly hi and does not overshoot.
REQ-008 DOWN SHALL drive _updown=0.
- When dcout==lo+1: decrement the remaining-sweep count.
- If the count reaches 0: go to DONE; otherwise go to UP.
- The counter bottoms at exactly lo.
REQ-009 When hi==lo+1, the turnaround comparisons SHALL still hold: UP exits on its first cycle (dcout==lo); DOWN exits on its first cycle (dcout==hi).
REQ-010 overflow=1 while in UP or DOWN SHALL force ERR on the next edge.
REQ-011 DONE SHALL pulse done=1 for one cycle, then go to IDLE.
REQ-012 ERR SHALL set err=1 and then go to IDLE.
REQ-013 busy SHALL be 1 in LOAD, UP and DOWN, and 0 otherwise.
REQ-014 abort=1 SHALL take priority over start and over every other transition.
- Next state is IDLE.
- done is not asserted and err is unchanged.
REQ-015 start while busy=1 SHALL be ignored.
REQ-016 In IDLE, DONE and ERR, _updown SHALL hold its last value; lo, hi and cycles SHALL not change outside IDLE.

Reset
REQ-017 _areset=1 SHALL immediately force the following, independent of clk:
- state=IDLE.
- _load=1, preld_val=0, _updown=1, _wrapstop=0.
- busy=0, done=0, err=0.
- remaining-sweep count=0.
REQ-018 Reset asserted mid-sweep SHALL abandon the job with no done pulse; the first start after release SHALL be accepted normally.

Configuration
REQ-019 Macro COUNTER8_CTRL_TIMEOUT_EN SHALL control a leg watchdog.
- Defined: a 9-bit leg timer clears on every entry to UP or DOWN and increments each cycle in UP/DOWN. Reaching 300 forces ERR on the next edge. The timer resets to 0 on _areset.
- Undefined: no timer logic exists, and UP/DOWN wait indefinitely for the turnaround value.

Verification
REQ-020 Basic job, with a behavioural counter model attached: lo=10, hi=13, cycles=2, start pulse ->
- _load=0 for one cycle with preld_val=10.
- dcout sequence 10,11,12,13,12,11,10,11,12,13,12,11,10.
- done pulses once; busy falls with done; err=0.
REQ-021 Rejected parameters:
- lo=20, hi=20, start -> err=1 within 2 cycles, _load never 0, busy stays 0.
- cycles=0 -> same result.
REQ-022 Minimum span: lo=0, hi=1, cycles=1 -> dcout sequence 0,1,0 and done pulses.
REQ-023 Overflow: counter model forced to raise overflow=1 during UP -> ERR next edge, err=1, busy=0, no done pulse.
REQ-024 Interrupted jobs:
- abort asserted in DOWN -> IDLE next edge with no done pulse; a new start (lo=5, hi=9, cycles=1) then completes normally.
- _areset pulse in UP -> all outputs at reset values immediately.
REQ-025 With COUNTER8_CTRL_TIMEOUT_EN defined and the counter model frozen at dcout=50 in UP (hi=100) -> err=1 exactly 301 cycles after UP entry.
- Without the macro, the same stimulus leaves busy=1 indefinitely.

Source files
------------

// File: rtl/counter8_ctrl.sv
`timescale 1ns/1ps
// counter8_ctrl: sequences an external 8-bit up/down counter through
// `cycles` sweeps of lo -> hi -> lo.
// The controller preloads the counter with lo and then steers its direction.
// The counter's registered value is fed back on dcout.
// Optional leg watchdog: define COUNTER8_CTRL_TIMEOUT_EN.
// With the watchdog, a sweep leg stuck for 300 cycles raises err.
module counter8_ctrl (
    input  logic       clk,
    input  logic       _areset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] lo_val,
    input  logic [7:0] hi_val,
    input  logic [3:0] cycles,
    input  logic [7:0] dcout,
    input  logic       overflow,
    output logic       _load,
    output logic [7:0] preld_val,
    output logic       _updown,
    output logic       _wrapstop,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_UP    = 3'd2,
        S_DOWN  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] lo_q, lo_d;
    logic [7:0] hi_q, hi_d;
    logic [3:0] rem_q, rem_d;

    logic       load_q, load_d;
    logic [7:0] preld_q, preld_d;
    logic       updown_q, updown_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       start_ok;
    logic       at_peak;
    logic       at_floor;
    logic       leg_timeout;

    // A start only counts when sitting in IDLE and not overridden by abort.
    assign start_ok = (state_q == S_IDLE) && start && !abort;
    // Turn one step early: the counter advances once more on the edge
    // that moves us to the other leg, so it lands exactly on hi / lo.
    assign at_peak  = (dcout == (hi_q - 8'd1));
    assign at_floor = (dcout == (lo_q + 8'd1));

`ifdef COUNTER8_CTRL_TIMEOUT_EN
    logic [8:0] leg_timer_q, leg_timer_d;

    // Leg timer: zero on entry to a leg, counts every cycle spent in a leg.
    always_comb begin
        leg_timer_d = 9'd0;
        if ((state_d == S_UP || state_d == S_DOWN) && (state_d != state_q)) begin
            leg_timer_d = 9'd0;
        end else if (state_q == S_UP || state_q == S_DOWN) begin
            leg_timer_d = leg_timer_q + 9'd1;
        end
    end

    // Leg timer register.
    always_ff @(posedge clk or posedge _areset) begin
        if (_areset) begin
            leg_timer_q <= 9'd0;
        end else begin
            leg_timer_q <= leg_timer_d;
        end
    end

    assign leg_timeout = (leg_timer_q == 9'd300);
`else
    assign leg_timeout = 1'b0;
`endif

    // State and job-parameter registers.
    always_ff @(posedge clk or posedge _areset) begin
        if (_areset) begin
            state_q <= S_IDLE;
            lo_q    <= 8'd0;
            hi_q    <= 8'd0;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state logic; abort beats everything, then overflow/timeout, then turnaround.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        rem_d   = rem_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        lo_d  = lo_val;
                        hi_d  = hi_val;
                        rem_d = cycles;
                        if ((lo_val >= hi_val) || (cycles == 4'd0)) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
                S_LOAD: state_d = S_UP;
                S_UP: begin
                    if (overflow || leg_timeout) begin
                        state_d = S_ERR;
                    end else if (at_peak) begin
                        state_d = S_DOWN;
                    end
                end
                S_DOWN: begin
                    if (overflow || leg_timeout) begin
                        state_d = S_ERR;
                    end else if (at_floor) begin
                        rem_d = rem_q - 4'd1;
                        if (rem_q == 4'd1) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_UP;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode from the next state so the registered outputs line up with the state.
    always_comb begin
        load_d   = 1'b1;
        preld_d  = preld_q;
        updown_d = updown_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;
        if (start_ok) begin
            err_d = 1'b0;
        end
        case (state_d)
            S_LOAD: begin
                load_d  = 1'b0;
                preld_d = lo_d;
                busy_d  = 1'b1;
            end
            S_UP: begin
                updown_d = 1'b1;
                busy_d   = 1'b1;
            end
            S_DOWN: begin
                updown_d = 1'b0;
                busy_d   = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            S_ERR:   err_d  = 1'b1;
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge _areset) begin
        if (_areset) begin
            load_q   <= 1'b1;
            preld_q  <= 8'd0;
            updown_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            load_q   <= load_d;
            preld_q  <= preld_d;
            updown_q <= updown_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign _load     = load_q;
    assign preld_val = preld_q;
    assign _updown   = updown_q;
    assign _wrapstop = 1'b0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_counter8_ctrl.sv
`timescale 1ns/1ps
// tb_counter8_ctrl: random and directed sweep jobs against counter8_ctrl.
// A behavioural counter is attached to the controller.
// The driver pushes the expected outcome of each job into a scoreboard.
// A negedge monitor pops and checks an entry whenever the DUT reports an event.
module tb_counter8_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       areset, start, abort, overflow;
    logic [7:0] lo_val, hi_val, dcout, preld_val;
    logic [3:0] cycles;
    logic       n_load, n_updown, n_wrapstop, busy, done, err;

    counter8_ctrl dut (
        .clk(clk), ._areset(areset), .start(start), .abort(abort),
        .lo_val(lo_val), .hi_val(hi_val), .cycles(cycles),
        .dcout(dcout), .overflow(overflow),
        ._load(n_load), .preld_val(preld_val), ._updown(n_updown),
        ._wrapstop(n_wrapstop), .busy(busy), .done(done), .err(err)
    );

    // Behavioural stop-and-flag counter, with hooks to freeze it or force overflow.
    logic [7:0] cnt = 8'd0;
    logic       ovf_q = 1'b0;
    logic       freeze, force_ovf;
    logic [7:0] freeze_val;
    always @(posedge clk) begin
        if (!freeze) begin
            if (!n_load) begin
                cnt   <= preld_val;
                ovf_q <= 1'b0;
            end else if (n_updown) begin
                if (cnt == 8'hFF) ovf_q <= 1'b1;
                else              cnt   <= cnt + 8'd1;
            end else begin
                if (cnt == 8'h00) ovf_q <= 1'b1;
                else              cnt   <= cnt - 8'd1;
            end
        end
    end
    assign dcout    = freeze ? freeze_val : cnt;
    assign overflow = ovf_q | force_ovf;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    localparam int K_DONE  = 0;
    localparam int K_ERR   = 1;
    localparam int K_ABORT = 2;
    localparam int K_RESET = 3;

    typedef struct {
        int kind;
        int lo;
        int hi;
        int ncyc;
        int issue;
        int lat_min;
        int lat_max;
        int exp_loads;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic take(input int kind, input string what, output exp_t e, output bit ok);
        checks++;
        e  = '{default: 0};
        ok = 1'b0;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: got an event with nothing pending, expected kind %0d pending", what, kind);
        end else begin
            e  = sb.pop_front();
            ok = (e.kind == kind);
            if (!ok) begin
                errors++;
                $display("FAIL %s: got event for kind %0d expected kind %0d", what, e.kind, kind);
            end
        end
    endtask

    // ------------------------------------------------------------ monitor
    int   m_trace[$];
    int   m_loads;
    bit   m_busy_seen;
    int   m_last_preld;
    logic m_err_prev;
    logic m_rst_prev;
    bit   m_abort_chk;
    logic m_err_at_abort;

    initial begin : monitor
        exp_t e;
        bit   ok;
        int   lat;
        int   exp_tr[$];
        int   bad;
        m_trace.delete();
        m_loads = 0; m_busy_seen = 0; m_last_preld = 0;
        m_err_prev = 1'b0; m_rst_prev = 1'b0; m_abort_chk = 0; m_err_at_abort = 1'b0;
        forever begin
            @(negedge clk);
            if (m_abort_chk) begin
                m_abort_chk = 0;
                chk("abort_busy", int'(busy), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_err", int'(err), int'(m_err_at_abort));
            end
            if (areset && !m_rst_prev) begin
                take(K_RESET, "reset_event", e, ok);
                if (ok) begin
                    chk("reset_load_n", int'(n_load), 1);
                    chk("reset_preld", int'(preld_val), 0);
                    chk("reset_updown", int'(n_updown), 1);
                    chk("reset_wrapstop", int'(n_wrapstop), 0);
                    chk("reset_busy", int'(busy), 0);
                    chk("reset_done", int'(done), 0);
                    chk("reset_err", int'(err), 0);
                end
                m_trace.delete(); m_loads = 0; m_busy_seen = 0;
            end else if (!areset) begin
                if (!n_load) begin
                    m_loads++;
                    m_last_preld = int'(preld_val);
                end
                if (busy) m_busy_seen = 1;
                if (busy && n_load) m_trace.push_back(int'(dcout));
                if (abort) begin
                    take(K_ABORT, "abort_event", e, ok);
                    m_err_at_abort = err;
                    m_abort_chk = 1;
                    m_trace.delete(); m_loads = 0; m_busy_seen = 0;
                end else if (done) begin
                    m_trace.push_back(int'(dcout));
                    take(K_DONE, "done_event", e, ok);
                    if (ok) begin
                        lat = cyc - e.issue;
                        chk("done_latency", lat, e.lat_min);
                        chk("done_loads", m_loads, 1);
                        chk("done_preld", m_last_preld, e.lo);
                        chk("done_err", int'(err), 0);
                        chk("done_busy", int'(busy), 0);
                        // expected sweep: lo up to hi and back, ncyc times, ending on lo
                        exp_tr.delete();
                        for (int c = 0; c < e.ncyc; c++) begin
                            for (int v = e.lo; v < e.hi; v++) exp_tr.push_back(v);
                            for (int v = e.hi; v > e.lo; v--) exp_tr.push_back(v);
                        end
                        exp_tr.push_back(e.lo);
                        checks++;
                        if (m_trace.size() != exp_tr.size()) begin
                            errors++;
                            $display("FAIL trace_len: got %0d expected %0d (lo=%0d hi=%0d cyc=%0d)",
                                     m_trace.size(), exp_tr.size(), e.lo, e.hi, e.ncyc);
                        end else begin
                            bad = -1;
                            for (int i = 0; i < exp_tr.size(); i++)
                                if (bad < 0 && m_trace[i] != exp_tr[i]) bad = i;
                            if (bad >= 0) begin
                                errors++;
                                $display("FAIL trace[%0d]: got %0d expected %0d", bad, m_trace[bad], exp_tr[bad]);
                            end
                        end
                        $display("job done lo=%0d hi=%0d cycles=%0d latency=%0d samples=%0d",
                                 e.lo, e.hi, e.ncyc, lat, m_trace.size());
                    end
                    m_trace.delete(); m_loads = 0; m_busy_seen = 0;
                end else if (err && !m_err_prev) begin
                    take(K_ERR, "err_event", e, ok);
                    if (ok) begin
                        lat = cyc - e.issue;
                        checks++;
                        if (lat < e.lat_min || lat > e.lat_max) begin
                            errors++;
                            $display("FAIL err_latency: got %0d expected %0d..%0d", lat, e.lat_min, e.lat_max);
                        end
                        chk("err_loads", m_loads, e.exp_loads);
                        chk("err_busy_seen", int'(m_busy_seen), int'(e.exp_loads != 0));
                        chk("err_busy", int'(busy), 0);
                        chk("err_done", int'(done), 0);
                        $display("job err lo=%0d hi=%0d cycles=%0d latency=%0d", e.lo, e.hi, e.ncyc, lat);
                    end
                    m_trace.delete(); m_loads = 0; m_busy_seen = 0;
                end
            end
            m_err_prev = err;
            m_rst_prev = areset;
        end
    end

    // ------------------------------------------------------------ driver
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int kind, input int lo, input int hi, input int ncyc,
                            input int lmin, input int lmax, input int loads);
        exp_t e;
        e.kind = kind; e.lo = lo; e.hi = hi; e.ncyc = ncyc;
        e.issue = cyc; e.lat_min = lmin; e.lat_max = lmax; e.exp_loads = loads;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending after %0d cycles expected 0", sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic run_job(input int lo, input int hi, input int c, input bit junk);
        int lat;
        lo_val = 8'(lo); hi_val = 8'(hi); cycles = 4'(c);
        start = 1'b1;
        if (lo >= hi || c == 0) begin
            lat = 2;
            push_exp(K_ERR, lo, hi, c, 1, 2, 0);
        end else begin
            lat = 2 + 2 * (hi - lo) * c;
            push_exp(K_DONE, lo, hi, c, lat, lat, 1);
        end
        tick(1);
        start  = 1'b0;
        lo_val = 8'($urandom); hi_val = 8'($urandom); cycles = 4'($urandom);
        if (junk && lat > 2) begin
            tick(int'($urandom_range(0, lat - 3)));
            start = 1'b1;
            tick(1);
            start = 1'b0;
        end
        wait_drain(lat + 20);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int  k, lo, hi, c, sel;
        bit  last_err;
        areset = 1'b1; start = 1'b0; abort = 1'b0;
        lo_val = 8'd0; hi_val = 8'd0; cycles = 4'd0;
        freeze = 1'b0; force_ovf = 1'b0; freeze_val = 8'd0;
        push_exp(K_RESET, 0, 0, 0, 0, 0, 0);
        tick(3);
        areset = 1'b0;
        tick(2);
        wait_drain(2);

        // basic job, rejected parameters, minimum span
        run_job(10, 13, 2, 0);
        run_job(20, 20, 3, 0);
        run_job(5, 9, 1, 0);
        run_job(20, 30, 0, 0);
        run_job(0, 1, 1, 0);
        run_job(7, 8, 3, 1);

        // overflow forced during UP
        lo_val = 8'd10; hi_val = 8'd200; cycles = 4'd1; start = 1'b1;
        push_exp(K_ERR, 10, 200, 1, 8, 8, 1);
        tick(1);
        start = 1'b0;
        tick(6);
        force_ovf = 1'b1;
        tick(1);
        force_ovf = 1'b0;
        wait_drain(20);
        run_job(3, 7, 2, 0);

        // abort in DOWN, then a normal job
        lo_val = 8'd10; hi_val = 8'd20; cycles = 4'd2; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        k = 0;
        while (!(busy && !n_updown) && k < 60) begin
            tick(1);
            k++;
        end
        chk("reach_down", int'(k < 60), 1);
        tick(2);
        push_exp(K_ABORT, 10, 20, 2, 0, 0, 0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        wait_drain(5);
        run_job(5, 9, 1, 0);

        // reset pulse in UP, then a normal job
        lo_val = 8'd10; hi_val = 8'd100; cycles = 4'd1; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        push_exp(K_RESET, 0, 0, 0, 0, 0, 0);
        #1 areset = 1'b1;
        tick(1);
        areset = 1'b0;
        wait_drain(3);
        run_job(5, 9, 1, 0);

        // randomized jobs; never two rejections back to back, as err is sticky
        last_err = 0;
        for (int j = 0; j < 25; j++) begin
            lo = int'($urandom_range(0, 230));
            hi = lo + int'($urandom_range(1, 12));
            c  = int'($urandom_range(1, 4));
            if (!last_err && $urandom_range(0, 4) == 0) begin
                sel = int'($urandom_range(0, 2));
                if (sel == 0)      hi = lo;
                else if (sel == 1) hi = int'($urandom_range(0, lo));
                else               c  = 0;
            end
            last_err = (lo >= hi || c == 0);
            run_job(lo, hi, c, bit'($urandom_range(0, 1)));
        end

        // counter stuck below the turnaround value
        freeze_val = 8'd50;
        freeze = 1'b1;
        lo_val = 8'd10; hi_val = 8'd100; cycles = 4'd1; start = 1'b1;
`ifdef COUNTER8_CTRL_TIMEOUT_EN
        push_exp(K_ERR, 10, 100, 1, 303, 303, 1);
        tick(1);
        start = 1'b0;
        wait_drain(400);
`else
        tick(1);
        start = 1'b0;
        tick(400);
        chk("stuck_busy", int'(busy), 1);
        push_exp(K_ABORT, 10, 100, 1, 0, 0, 0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        wait_drain(5);
`endif
        freeze = 1'b0;

        tick(5);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
